rect_plotter: RTL and testbench

//  Consumes one move request from the game-logic stage (old/new corner, size, start pulse).
//  For each request it erases the old rectangle with BG_COLOUR, then draws the new one with obj_colour.

---
 rtl/plot_pkg.sv | 32 +++
 rtl/rect_plotter_if.sv | 31 +++
 rtl/rect_scan.sv | 52 +++++
 rtl/rect_plotter.sv | 135 +++++++++++++
 tb/tb_rect_plotter.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/plot_pkg.sv
// Shared types and constants for the rectangle plotter: FSM encoding, screen
// geometry, coordinate widths, colours and the latched request record.
package plot_pkg;

  localparam int X_W      = 8;
  localparam int Y_W      = 7;
  localparam int COLOUR_W = 3;

  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;

  localparam logic [COLOUR_W-1:0] COLOUR_BLACK = 3'b000;
  localparam logic [COLOUR_W-1:0] COLOUR_WHITE = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ERASE,
    ST_DRAW,
    ST_FIN
  } plot_state_t;

  typedef struct packed {
    logic [X_W-1:0]      old_x;
    logic [Y_W-1:0]      old_y;
    logic [X_W-1:0]      new_x;
    logic [Y_W-1:0]      new_y;
    logic [X_W-1:0]      size_x;
    logic [Y_W-1:0]      size_y;
    logic [COLOUR_W-1:0] colour;
  } plot_req_t;

endpackage

// File: rtl/rect_plotter_if.sv
// Request/status/pixel bundle between game logic (master) and the
// rectangle plotter (slave); the vga_* group feeds the VGA adapter.
interface rect_plotter_if;
  import plot_pkg::*;

  logic                start;
  logic [X_W-1:0]      new_x;
  logic [Y_W-1:0]      new_y;
  logic [X_W-1:0]      old_x;
  logic [Y_W-1:0]      old_y;
  logic [X_W-1:0]      size_x;
  logic [Y_W-1:0]      size_y;
  logic [COLOUR_W-1:0] obj_colour;
  logic                busy;
  logic                done;
  logic [X_W-1:0]      vga_x;
  logic [Y_W-1:0]      vga_y;
  logic [COLOUR_W-1:0] vga_colour;
  logic                vga_plot;

  modport master (
    output start, new_x, new_y, old_x, old_y, size_x, size_y, obj_colour,
    input  busy, done, vga_x, vga_y, vga_colour, vga_plot
  );

  modport slave (
    input  start, new_x, new_y, old_x, old_y, size_x, size_y, obj_colour,
    output busy, done, vga_x, vga_y, vga_colour, vga_plot
  );

endinterface

// File: rtl/rect_scan.sv
// Raster counter over a size_x by size_y rectangle, x fastest. Exposes the
// next counter values so the owner can register pixel outputs in step.
module rect_scan
  import plot_pkg::*;
(
  input  logic           clk,
  input  logic           resetn,
  input  logic           clr,
  input  logic           step,
  input  logic [X_W-1:0] size_x,
  input  logic [Y_W-1:0] size_y,
  output logic [X_W-1:0] nxt_cx,
  output logic [Y_W-1:0] nxt_cy,
  output logic           last
);

  logic [X_W-1:0] cx;
  logic [Y_W-1:0] cy;
  logic           row_end;

  assign row_end = (cx == size_x - 8'd1);
  assign last    = row_end && (cy == size_y - 7'd1);

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    nxt_cx = cx;
    nxt_cy = cy;
    if (clr) begin
      nxt_cx = '0;
      nxt_cy = '0;
    end else if (step) begin
      if (row_end) begin
        nxt_cx = '0;
        nxt_cy = cy + 7'd1;
      end else begin
        nxt_cx = cx + 8'd1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cx <= '0;
      cy <= '0;
    end else begin
      cx <= nxt_cx;
      cy <= nxt_cy;
    end
  end

endmodule

// File: rtl/rect_plotter.sv
// Erases the old rectangle then draws the new one, one registered pixel per clock.
// Optional PLOT_OVERLAP_SKIP_EN: erase pixels inside the new rectangle are not strobed.
module rect_plotter
  import plot_pkg::*;
#(
  parameter int                  MAX_X     = SCREEN_W - 1,
  parameter int                  MAX_Y     = SCREEN_H - 1,
  parameter logic [COLOUR_W-1:0] BG_COLOUR = COLOUR_BLACK
) (
  input logic           clk,
  input logic           resetn,
  rect_plotter_if.slave bus
);

  localparam logic [X_W:0] MAX_X_V = (X_W+1)'(MAX_X);
  localparam logic [Y_W:0] MAX_Y_V = (Y_W+1)'(MAX_Y);

  plot_state_t         state, nxt_state;
  plot_req_t           req_q, live, req;
  logic                clr, step, last, emitting, on_screen, skip;
  logic [X_W-1:0]      nxt_cx, base_x;
  logic [Y_W-1:0]      nxt_cy, base_y;
  logic [X_W:0]        sum_x;
  logic [Y_W:0]        sum_y;
  logic                busy_q, done_q, plot_q;
  logic [X_W-1:0]      x_q;
  logic [Y_W-1:0]      y_q;
  logic [COLOUR_W-1:0] colour_q;

  always_comb begin
    live = '{old_x: bus.old_x, old_y: bus.old_y, new_x: bus.new_x, new_y: bus.new_y,
             size_x: bus.size_x, size_y: bus.size_y, colour: bus.obj_colour};
  end

  // The first pixel is registered on the accepting edge, before req_q holds the request.
  assign req = (state == ST_IDLE) ? live : req_q;

  always_comb begin
    nxt_state = state;
    clr       = 1'b0;
    step      = 1'b0;
    unique case (state)
      ST_IDLE: begin
        clr = 1'b1;
        if (bus.start)
          nxt_state = (live.size_x == '0 || live.size_y == '0) ? ST_FIN : ST_ERASE;
      end
      ST_ERASE: begin
        if (last) begin
          nxt_state = ST_DRAW;
          clr       = 1'b1;
        end else begin
          step = 1'b1;
        end
      end
      ST_DRAW: begin
        if (last) begin
          nxt_state = ST_FIN;
          clr       = 1'b1;
        end else begin
          step = 1'b1;
        end
      end
      ST_FIN: begin
        nxt_state = ST_IDLE;
        clr       = 1'b1;
      end
      default: nxt_state = ST_IDLE;
    endcase
  end

  rect_scan u_scan (
    .clk    (clk),
    .resetn (resetn),
    .clr    (clr),
    .step   (step),
    .size_x (req_q.size_x),
    .size_y (req_q.size_y),
    .nxt_cx (nxt_cx),
    .nxt_cy (nxt_cy),
    .last   (last)
  );

  assign emitting  = (nxt_state == ST_ERASE) || (nxt_state == ST_DRAW);
  assign base_x    = (nxt_state == ST_ERASE) ? req.old_x : req.new_x;
  assign base_y    = (nxt_state == ST_ERASE) ? req.old_y : req.new_y;
  assign sum_x     = {1'b0, base_x} + {1'b0, nxt_cx};
  assign sum_y     = {1'b0, base_y} + {1'b0, nxt_cy};
  assign on_screen = (sum_x <= MAX_X_V) && (sum_y <= MAX_Y_V);

`ifdef PLOT_OVERLAP_SKIP_EN
  logic [X_W:0] new_x_end;
  logic [Y_W:0] new_y_end;
  assign new_x_end = {1'b0, req.new_x} + {1'b0, req.size_x};
  assign new_y_end = {1'b0, req.new_y} + {1'b0, req.size_y};
  assign skip = (nxt_state == ST_ERASE)
             && (sum_x >= {1'b0, req.new_x}) && (sum_x < new_x_end)
             && (sum_y >= {1'b0, req.new_y}) && (sum_y < new_y_end);
`else
  assign skip = 1'b0;
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= ST_IDLE;
      req_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      plot_q   <= 1'b0;
      x_q      <= '0;
      y_q      <= '0;
      colour_q <= BG_COLOUR;
    end else begin
      state  <= nxt_state;
      busy_q <= emitting;
      done_q <= (nxt_state == ST_FIN);
      plot_q <= emitting && on_screen && !skip;
      if (state == ST_IDLE && bus.start)
        req_q <= live;
      if (emitting) begin
        x_q      <= sum_x[X_W-1:0];
        y_q      <= sum_y[Y_W-1:0];
        colour_q <= (nxt_state == ST_ERASE) ? BG_COLOUR : req.colour;
      end
    end
  end

  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.vga_plot   = plot_q;
  assign bus.vga_x      = x_q;
  assign bus.vga_y      = y_q;
  assign bus.vga_colour = colour_q;

endmodule

// File: tb/tb_rect_plotter.sv
// Self-checking bench for rect_plotter: directed move requests plus random ones,
// compared cycle by cycle against a pixel-list model built from plain loops.
module tb_rect_plotter;
  import plot_pkg::*;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  rect_plotter_if bus ();

  rect_plotter dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected per-cycle pixel stream for one request.
  bit ex_p[$];
  int ex_x[$];
  int ex_y[$];
  int ex_c[$];

  function automatic void build(input int ox, oy, nx, ny, sx, sy, col);
    ex_p.delete(); ex_x.delete(); ex_y.delete(); ex_c.delete();
    for (int ph = 0; ph < 2; ph++) begin
      for (int cy = 0; cy < sy; cy++) begin
        for (int cx = 0; cx < sx; cx++) begin
          int  px = (ph == 0 ? ox : nx) + cx;
          int  py = (ph == 0 ? oy : ny) + cy;
          bit  vis = (px < SCREEN_W) && (py < SCREEN_H);
`ifdef PLOT_OVERLAP_SKIP_EN
          if (ph == 0 && px >= nx && px < nx + sx && py >= ny && py < ny + sy) vis = 0;
`endif
          ex_p.push_back(vis);
          ex_x.push_back(px);
          ex_y.push_back(py);
          ex_c.push_back(ph == 0 ? 0 : col);
        end
      end
    end
  endfunction

  task automatic scramble_inputs();
    bus.old_x      = 8'($urandom);
    bus.old_y      = 7'($urandom);
    bus.new_x      = 8'($urandom);
    bus.new_y      = 7'($urandom);
    bus.size_x     = 8'($urandom);
    bus.size_y     = 7'($urandom);
    bus.obj_colour = 3'($urandom);
  endtask

  // restart_cycle / abort_cycle / want_done / want_strobes: 0 or negative disables.
  task automatic run_req(input int ox, oy, nx, ny, sx, sy, col,
                         input int restart_cycle, abort_cycle, want_done, want_strobes);
    int n, exp_strobes, strobes, done_at;
    build(ox, oy, nx, ny, sx, sy, col);
    n = ex_p.size();
    exp_strobes = 0;
    foreach (ex_p[i]) exp_strobes += int'(ex_p[i]);
    strobes = 0;
    done_at = -1;

    @(negedge clk);
    bus.old_x = 8'(ox); bus.old_y = 7'(oy);
    bus.new_x = 8'(nx); bus.new_y = 7'(ny);
    bus.size_x = 8'(sx); bus.size_y = 7'(sy);
    bus.obj_colour = 3'(col);
    bus.start = 1'b1;

    for (int c = 1; c <= n + 1; c++) begin
      @(negedge clk);
      if (c == 1) begin
        bus.start = 1'b0;
        scramble_inputs();
      end
      if (c == restart_cycle) begin
        scramble_inputs();
        bus.size_x = 8'd2; bus.size_y = 7'd2;
        bus.start = 1'b1;
      end
      if (c == restart_cycle + 1) bus.start = 1'b0;
      if (c == abort_cycle) begin
        resetn = 1'b0;
        #1;
        check("abort_plot", 32'(bus.vga_plot), 0);
        check("abort_busy", 32'(bus.busy), 0);
        check("abort_done", 32'(bus.done), 0);
        check("abort_x", 32'(bus.vga_x), 0);
        check("abort_colour", 32'(bus.vga_colour), 0);
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        check("post_abort_plot", 32'(bus.vga_plot), 0);
        check("post_abort_busy", 32'(bus.busy), 0);
        return;
      end
      if (bus.done === 1'b1 && done_at < 0) done_at = c;
      if (bus.vga_plot === 1'b1) strobes++;
      if (c <= n) begin
        check("pix_plot", 32'(bus.vga_plot), 32'(ex_p[c-1]));
        if (ex_p[c-1]) begin
          check("pix_x", 32'(bus.vga_x), 32'(ex_x[c-1]));
          check("pix_y", 32'(bus.vga_y), 32'(ex_y[c-1]));
          check("pix_colour", 32'(bus.vga_colour), 32'(ex_c[c-1]));
        end
        check("busy_active", 32'(bus.busy), 1);
        check("done_early", 32'(bus.done), 0);
      end else begin
        check("done_pulse", 32'(bus.done), 1);
        check("busy_at_done", 32'(bus.busy), 0);
        check("plot_at_done", 32'(bus.vga_plot), 0);
      end
    end

    @(negedge clk);
    check("idle_done", 32'(bus.done), 0);
    check("idle_busy", 32'(bus.busy), 0);
    check("idle_plot", 32'(bus.vga_plot), 0);
    check("strobe_count", 32'(strobes), 32'(exp_strobes));
    if (want_done > 0)    check("done_cycle", 32'(done_at), 32'(want_done));
    if (want_strobes > 0) check("strobes_directed", 32'(strobes), 32'(want_strobes));
  endtask

  initial begin
    bus.start = 1'b0;
    bus.old_x = '0; bus.old_y = '0; bus.new_x = '0; bus.new_y = '0;
    bus.size_x = '0; bus.size_y = '0; bus.obj_colour = '0;
    resetn = 1'b0;
    #12;
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_done", 32'(bus.done), 0);
    check("rst_plot", 32'(bus.vga_plot), 0);
    check("rst_x", 32'(bus.vga_x), 0);
    check("rst_y", 32'(bus.vga_y), 0);
    check("rst_colour", 32'(bus.vga_colour), 0);
    @(negedge clk);
    resetn = 1'b1;

    // Overlapping one-pixel move.
`ifdef PLOT_OVERLAP_SKIP_EN
    run_req(10, 20, 11, 20, 4, 4, 7, 0, 0, 33, 20);
`else
    run_req(10, 20, 11, 20, 4, 4, 7, 0, 0, 33, 32);
`endif
    // Zero width: only the done pulse.
    run_req(10, 20, 11, 20, 0, 4, 7, 0, 0, 1, 0);
    // Bottom-right corner clipping.
`ifdef PLOT_OVERLAP_SKIP_EN
    run_req(158, 118, 158, 118, 4, 4, 5, 0, 0, 33, 4);
`else
    run_req(158, 118, 158, 118, 4, 4, 5, 0, 0, 33, 8);
`endif
    // Second start mid-request is ignored.
    run_req(40, 50, 90, 60, 4, 4, 3, 5, 0, 33, 32);
    // Reset mid-request, then a clean restart.
    run_req(10, 20, 30, 40, 4, 4, 6, 0, 10, 0, 0);
`ifdef PLOT_OVERLAP_SKIP_EN
    run_req(10, 20, 11, 20, 4, 4, 7, 0, 0, 33, 20);
`else
    run_req(10, 20, 11, 20, 4, 4, 7, 0, 0, 33, 32);
`endif

    // Random requests, including off-screen and zero-size ones.
    for (int i = 0; i < 16; i++) begin
      int ox = $urandom_range(0, 255);
      int oy = $urandom_range(0, 127);
      int nx = (i % 2 == 0) ? ox + $urandom_range(0, 3) - 1 : $urandom_range(0, 255);
      int ny = (i % 2 == 0) ? oy + $urandom_range(0, 3) - 1 : $urandom_range(0, 127);
      if (nx < 0) nx = 0;
      if (nx > 255) nx = 255;
      if (ny < 0) ny = 0;
      if (ny > 127) ny = 127;
      run_req(ox, oy, nx, ny, $urandom_range(0, 6), $urandom_range(0, 5),
              $urandom_range(0, 7), 0, 0, 0, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
